// File: rtl/iterative_shift_rotate_unit.sv
// Multi-cycle shift/rotate engine: one 1-bit step per clock, result over valid/ready.
// Optional Carry_Out port enabled by defining SHIFT_CARRY_OUT_EN.
module iterative_shift_rotate_unit #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Sel,
    input  logic [AMT_W-1:0] Amt,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SHIFT_CARRY_OUT_EN
    ,
    output logic             Carry_Out
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] step_val;
    logic             rot_q;
    logic             left_q;
    logic [AMT_W-1:0] cnt_q;
    logic             accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Out       = work_q;
    assign accept    = in_valid && in_ready;

    // One 1-bit move of the working register, chosen by the captured opcode.
    always_comb begin
        unique case ({rot_q, left_q})
            2'b00:   step_val = {1'b0, work_q[WIDTH-1:1]};
            2'b01:   step_val = {work_q[WIDTH-2:0], 1'b0};
            2'b10:   step_val = {work_q[0], work_q[WIDTH-1:1]};
            default: step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        endcase
    end

    // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = (Amt == '0) ? DONE : BUSY;
            BUSY: if (cnt_q == AMT_W'(1)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

`ifdef SHIFT_CARRY_OUT_EN
    logic leaving_bit;
    assign leaving_bit = left_q ? work_q[WIDTH-1] : work_q[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q    <= '0;
            rot_q     <= 1'b0;
            left_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef SHIFT_CARRY_OUT_EN
            Carry_Out <= 1'b0;
`endif
        end else if (accept) begin
            work_q    <= Sel[1] ? B : A;
            rot_q     <= Sel[2];
            left_q    <= Sel[0];
            cnt_q     <= Amt;
`ifdef SHIFT_CARRY_OUT_EN
            Carry_Out <= 1'b0;
`endif
        end else if (state == BUSY) begin
            work_q    <= step_val;
            cnt_q     <= cnt_q - 1'b1;
`ifdef SHIFT_CARRY_OUT_EN
            Carry_Out <= leaving_bit;
`endif
        end
    end

endmodule

// File: tb/tb_iterative_shift_rotate_unit.sv
// Self-checking bench for iterative_shift_rotate_unit: directed cases plus
// randomized traffic compared against a closed-form shift/rotate model.
module tb_iterative_shift_rotate_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A, B;
    logic [2:0]   Sel;
    logic [2:0]   Amt;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Out;
    logic         out_valid;
    logic         out_ready;
`ifdef SHIFT_CARRY_OUT_EN
    logic         Carry_Out;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_accepted = 0;
    int cyc = 0;

    iterative_shift_rotate_unit #(.WIDTH(W), .AMT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Sel      (Sel),
        .Amt      (Amt),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Out      (Out),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef SHIFT_CARRY_OUT_EN
        ,
        .Carry_Out(Carry_Out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Closed-form result of an N-position shift/rotate and the last bit moved out.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] sel, input int n,
                                  output logic [W-1:0] res, output logic carry);
        int x, k, mask;
        mask = (1 << W) - 1;
        x = sel[1] ? int'(b) : int'(a);
        if (n == 0) begin
            res   = W'(x);
            carry = 1'b0;
        end else if (sel[2]) begin
            k = n % W;
            if (sel[0]) begin
                res   = W'(((x << k) | (x >> (W - k))) & mask);
                carry = 1'((x >> ((W - k) % W)) & 1);
            end else begin
                res   = W'(((x >> k) | (x << (W - k))) & mask);
                carry = 1'((x >> ((n - 1) % W)) & 1);
            end
        end else begin
            res = (n >= W) ? '0 : (sel[0] ? W'((x << n) & mask) : W'(x >> n));
            if (n > W)       carry = 1'b0;
            else if (sel[0]) carry = 1'((x >> (W - n)) & 1);
            else             carry = 1'((x >> (n - 1)) & 1);
        end
    endfunction

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        int           due;
    } txn_t;

    txn_t q[$];

    // Compare process: one outstanding request at most; outputs checked every cycle.
    logic pending;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            pending = (q.size() != 0);
            check("in_ready", in_ready, !pending);
            if (pending) begin
                if (cyc < q[0].due) begin
                    check("out_valid_busy", out_valid, 0);
                end else begin
                    check("out_valid_done", out_valid, 1);
                    check("out_value", Out, q[0].res);
`ifdef SHIFT_CARRY_OUT_EN
                    check("carry_out", Carry_Out, q[0].carry);
`endif
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                check("out_valid_idle", out_valid, 0);
                if (in_valid) begin
                    txn_t t;
                    model(A, B, Sel, int'(Amt), t.res, t.carry);
                    t.due = cyc + 1 + int'(Amt);
                    q.push_back(t);
                    n_accepted++;
                end
            end
        end
    end

    // Directed request with hand-computed expectations; out_ready assumed 1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                          input logic [2:0] amt, input logic [W-1:0] exp_out, input logic exp_c);
        int lat;
        @(posedge clk); #1;
        A = a; B = b; Sel = sel; Amt = amt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = ~a; B = ~b; Sel = ~sel; Amt = ~amt;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check("latency", lat, amt);
        check("directed_out", Out, exp_out);
`ifdef SHIFT_CARRY_OUT_EN
        check("directed_carry", Carry_Out, exp_c);
`else
        if (exp_c === 1'bx) check("directed_carry_arg", 0, 1);
`endif
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Sel = '0; Amt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out", Out, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
`ifdef SHIFT_CARRY_OUT_EN
        check("reset_carry", Carry_Out, 0);
`endif
        @(posedge clk); #1 rst = 1'b0;

        run_op(4'b1011, 4'b0000, 3'b000, 3'd2, 4'b0010, 1'b1);
        run_op(4'b1001, 4'b0110, 3'b111, 3'd5, 4'b1100, 1'b0);
        run_op(4'b1111, 4'b0000, 3'b001, 3'd7, 4'b0000, 1'b0);
        run_op(4'b1001, 4'b0000, 3'b100, 3'd0, 4'b1001, 1'b0);

        // Consumer stalls in DONE while a second request waits on the inputs.
        @(posedge clk); #1;
        out_ready = 1'b0;
        A = 4'b0101; Sel = 3'b101; Amt = 3'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 4'b0011; Sel = 3'b000; Amt = 3'd1;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin guard++; @(negedge clk); end
        for (int i = 0; i < 4; i++) begin
            check("stall_out", Out, 4'b1010);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", out_valid, 1);
        @(negedge clk);
        check("release_idle", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin lat++; @(negedge clk); end
        check("second_latency", lat, 1);
        check("second_out", Out, 4'b0001);
`ifdef SHIFT_CARRY_OUT_EN
        check("second_carry", Carry_Out, 1);
`endif
        @(posedge clk);

        // Reset in the middle of a six-step operation.
        @(posedge clk); #1;
        A = 4'b1101; Sel = 3'b100; Amt = 3'd6; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out", Out, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
`ifdef SHIFT_CARRY_OUT_EN
        check("abort_carry", Carry_Out, 0);
`endif
        run_op(4'b0110, 4'b0000, 3'b001, 3'd2, 4'b1000, 1'b1);

        // Randomized back-to-back traffic with a stalling consumer.
        guard = 0;
        while (n_accepted < 270 && guard < 20000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A   = W'($urandom);
            B   = W'($urandom);
            Sel = 3'($urandom);
            Amt = 3'($urandom);
            guard++;
        end
        if (guard >= 20000) check("random_budget", 0, 1);
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
